// File: rtl/jk_bank_arbiter.sv
// rtl/jk_bank_arbiter.sv - round-robin arbiter sequencing two requesters' JK operations into a shared bank
// Optional macro JK_ARB_FIXED_PRIO_EN: requester 0 always wins ties and no round-robin pointer is kept.
module jk_bank_arbiter #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req,
    input  logic [1:0]    op0,
    input  logic [IW-1:0] idx0,
    input  logic [1:0]    op1,
    input  logic [IW-1:0] idx1,
    output logic [1:0]    ack,
    output logic          busy,
    output logic [N-1:0]  j,
    output logic [N-1:0]  k,
    output logic [N-1:0]  q
);
    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_ACK} state_t;

    state_t        state;
    logic          winner;
    logic          pick1;
    logic [1:0]    sel_op;
    logic [IW-1:0] sel_idx;
    logic [N-1:0]  sel_mask;

`ifdef JK_ARB_FIXED_PRIO_EN
    assign pick1 = req[1] & ~req[0];
`else
    logic last;
    // On a tie, the requester not granted last time wins.
    assign pick1 = req[1] & (~req[0] | ~last);
`endif

    assign sel_op  = pick1 ? op1 : op0;
    assign sel_idx = pick1 ? idx1 : idx0;

    // Out-of-range indices (N not a power of two) select no bit at all.
    always_comb begin
        sel_mask = '0;
        for (int i = 0; i < N; i++) begin
            sel_mask[i] = (sel_idx == IW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            winner <= 1'b0;
            ack    <= 2'b00;
            busy   <= 1'b0;
            j      <= '0;
            k      <= '0;
            q      <= '0;
`ifndef JK_ARB_FIXED_PRIO_EN
            last   <= 1'b1;
`endif
        end else begin
            // j/k are zero outside DRIVE, so the bank only moves on the DRIVE->ACK edge.
            q <= (j & ~q) | (~k & q);
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        state  <= S_DRIVE;
                        busy   <= 1'b1;
                        winner <= pick1;
                        j      <= sel_op[1] ? sel_mask : '0;
                        k      <= sel_op[0] ? sel_mask : '0;
`ifndef JK_ARB_FIXED_PRIO_EN
                        last   <= pick1;
`endif
                    end
                end
                S_DRIVE: begin
                    state <= S_ACK;
                    j     <= '0;
                    k     <= '0;
                    ack   <= winner ? 2'b10 : 2'b01;
                end
                S_ACK: begin
                    state <= S_IDLE;
                    ack   <= 2'b00;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    ack   <= 2'b00;
                    busy  <= 1'b0;
                    j     <= '0;
                    k     <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_jk_bank_arbiter.sv
// tb/tb_jk_bank_arbiter.sv - directed self-checking bench for jk_bank_arbiter (N=8 and N=6 instances)
module tb_jk_bank_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] req = 2'b00;
    logic [1:0] op0 = 2'b00, op1 = 2'b00;
    logic [2:0] idx0 = 3'd0, idx1 = 3'd0;
    logic [1:0] ack;
    logic       busy;
    logic [7:0] j, k, q;

    logic [1:0] req6 = 2'b00;
    logic [1:0] op6 = 2'b00;
    logic [2:0] idx6 = 3'd0;
    logic [1:0] ack6;
    logic       busy6;
    logic [5:0] j6, k6, q6;

    int errors = 0;
    int checks = 0;

    logic       obs_busy, obs_idle_busy;
    logic [7:0] obs_j, obs_k, obs_q;
    logic [1:0] obs_ack, obs_idle_ack;

    always #5 clk = ~clk;

    jk_bank_arbiter #(.N(8)) dut (
        .clk(clk), .rst(rst), .req(req),
        .op0(op0), .idx0(idx0), .op1(op1), .idx1(idx1),
        .ack(ack), .busy(busy), .j(j), .k(k), .q(q)
    );

    jk_bank_arbiter #(.N(6)) dut6 (
        .clk(clk), .rst(rst), .req(req6),
        .op0(op6), .idx0(idx6), .op1(2'b00), .idx1(3'd0),
        .ack(ack6), .busy(busy6), .j(j6), .k(k6), .q(q6)
    );

    // Drives one request from IDLE through its ACK and records what was seen in DRIVE, ACK and the next IDLE.
    task automatic issue(input int r, input logic [1:0] op, input logic [2:0] idx);
        if (r == 0) begin op0 = op; idx0 = idx; end
        else begin op1 = op; idx1 = idx; end
        req[r] = 1'b1;
        @(negedge clk);
        obs_busy = busy; obs_j = j; obs_k = k;
        @(negedge clk);
        obs_q = q; obs_ack = ack;
        req[r] = 1'b0;
        @(negedge clk);
        obs_idle_ack = ack; obs_idle_busy = busy;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        req = 2'b00;
        req6 = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({ack, busy} !== 3'b000) begin errors++; $display("FAIL reset_ack_busy got=%b want=000", {ack, busy}); end
        checks++; if ({j, k, q} !== 24'h0) begin errors++; $display("FAIL reset_jkq got=%h want=000000", {j, k, q}); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_set();
        issue(0, 2'b10, 3'd3);
        checks++; if (obs_busy !== 1'b1) begin errors++; $display("FAIL set_busy got=%b want=1", obs_busy); end
        checks++; if (obs_j !== 8'h08 || obs_k !== 8'h00) begin errors++; $display("FAIL set_jk got=%h/%h want=08/00", obs_j, obs_k); end
        checks++; if (obs_q !== 8'h08) begin errors++; $display("FAIL set_q got=%h want=08", obs_q); end
        checks++; if (obs_ack !== 2'b01) begin errors++; $display("FAIL set_ack got=%b want=01", obs_ack); end
        checks++; if (obs_idle_ack !== 2'b00 || obs_idle_busy !== 1'b0) begin errors++; $display("FAIL set_ack_one_cycle got=%b/%b want=00/0", obs_idle_ack, obs_idle_busy); end
    endtask

    task automatic test_toggle();
        issue(1, 2'b11, 3'd3);
        checks++; if (obs_j !== 8'h08 || obs_k !== 8'h08) begin errors++; $display("FAIL tog3_jk got=%h/%h want=08/08", obs_j, obs_k); end
        checks++; if (obs_q !== 8'h00) begin errors++; $display("FAIL tog3_q got=%h want=00", obs_q); end
        checks++; if (obs_ack !== 2'b10) begin errors++; $display("FAIL tog3_ack got=%b want=10", obs_ack); end
        issue(1, 2'b11, 3'd0);
        checks++; if (obs_q !== 8'h01) begin errors++; $display("FAIL tog0_q got=%h want=01", obs_q); end
        checks++; if (obs_ack !== 2'b10) begin errors++; $display("FAIL tog0_ack got=%b want=10", obs_ack); end
    endtask

    task automatic test_tie();
        rst = 1'b0;
        req = 2'b11;
        op0 = 2'b10; idx0 = 3'd1;
        op1 = 2'b10; idx1 = 3'd6;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (j !== 8'h02) begin errors++; $display("FAIL tie_first_j got=%h want=02", j); end
        @(negedge clk);
        checks++; if (ack !== 2'b01) begin errors++; $display("FAIL tie_first_ack got=%b want=01", ack); end
        req[0] = 1'b0;
        @(negedge clk);
        checks++; if (ack !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL tie_gap got=%b/%b want=00/0", ack, busy); end
        @(negedge clk);
        checks++; if (j !== 8'h40) begin errors++; $display("FAIL tie_second_j got=%h want=40", j); end
        @(negedge clk);
        checks++; if (ack !== 2'b10) begin errors++; $display("FAIL tie_second_ack got=%b want=10", ack); end
        checks++; if (q !== 8'h42) begin errors++; $display("FAIL tie_q got=%h want=42", q); end
        req[1] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_hold();
        for (int b = 0; b < 8; b++) issue(b % 2, 2'b10, 3'(b));
        checks++; if (q !== 8'hFF) begin errors++; $display("FAIL hold_setup_q got=%h want=ff", q); end
        issue(0, 2'b00, 3'd5);
        checks++; if (obs_j !== 8'h00 || obs_k !== 8'h00) begin errors++; $display("FAIL hold_jk got=%h/%h want=00/00", obs_j, obs_k); end
        checks++; if (obs_q !== 8'hFF) begin errors++; $display("FAIL hold_q got=%h want=ff", obs_q); end
        checks++; if (obs_ack !== 2'b01) begin errors++; $display("FAIL hold_ack got=%b want=01", obs_ack); end
    endtask

    task automatic test_midreset();
        logic [1:0] seen;
        op0 = 2'b10; idx0 = 3'd2;
        req[0] = 1'b1;
        @(negedge clk);
        checks++; if (j !== 8'h04) begin errors++; $display("FAIL mid_drive_j got=%h want=04", j); end
        #1 rst = 1'b0;
        req[0] = 1'b0;
        #1;
        checks++; if ({q, j, k} !== 24'h0 || ack !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL mid_async_clear got=%h/%b/%b want=000000/00/0", {q, j, k}, ack, busy); end
        @(negedge clk);
        rst = 1'b1;
        seen = 2'b00;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            seen = seen | ack;
        end
        checks++; if (seen !== 2'b00) begin errors++; $display("FAIL mid_no_ack got=%b want=00", seen); end
        issue(0, 2'b10, 3'd2);
        checks++; if (obs_q !== 8'h04 || obs_ack !== 2'b01) begin errors++; $display("FAIL mid_reissue got=%h/%b want=04/01", obs_q, obs_ack); end
    endtask

    task automatic test_out_of_range();
        apply_reset();
        op6 = 2'b10; idx6 = 3'd5;
        req6 = 2'b01;
        @(negedge clk);
        @(negedge clk);
        req6 = 2'b00;
        @(negedge clk);
        checks++; if (q6 !== 6'h20) begin errors++; $display("FAIL n6_setup_q got=%h want=20", q6); end
        op6 = 2'b11; idx6 = 3'd7;
        req6 = 2'b01;
        @(negedge clk);
        checks++; if (busy6 !== 1'b1 || j6 !== 6'h00 || k6 !== 6'h00) begin errors++; $display("FAIL n6_oor_drive got=%b/%h/%h want=1/00/00", busy6, j6, k6); end
        @(negedge clk);
        checks++; if (ack6 !== 2'b01) begin errors++; $display("FAIL n6_oor_ack got=%b want=01", ack6); end
        checks++; if (q6 !== 6'h20) begin errors++; $display("FAIL n6_oor_q got=%h want=20", q6); end
        req6 = 2'b00;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_set();
        test_toggle();
        test_tie();
        test_hold();
        test_midreset();
        test_out_of_range();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/jk_bank_arbiter.md
# jk_bank_arbiter

Shares a bank of N JK flip-flops between two requesters. Each requester asks for one operation (hold, reset, set, toggle) on one bit through a req/ack handshake. The block arbitrates between the two requesters and sequences the winning request's J/K drive into the bank. It then returns an acknowledge. It sits above the single-bit JK-from-D flip-flop and turns a bank of those cells into a shared, command-driven state register.

## Interface
Parameters:
- `N`, default 8: number of JK bits in the bank. Legal range is 2 to 64.
- `IW`, default `$clog2(N)`: bit-index width. Derived; not overridden.

Ports:
- `clk`, input, 1: clock. Rising-edge active.
- `rst`, input, 1: reset. Asynchronous, active-low.
- `req`, input, 2: request per requester. `req[r]` is held high until `ack[r]`.
- `op0`, input, 2: requester 0 operation. 00 = hold, 01 = reset (J=0, K=1), 10 = set (J=1, K=0), 11 = toggle (J=1, K=1).
- `idx0`, input, IW: requester 0 target bit.
- `op1`, input, 2: requester 1 operation. Encoding as `op0`.
- `idx1`, input, IW: requester 1 target bit.
- `ack`, output, 2: one-cycle completion pulse per requester.
- `busy`, output, 1: high when the FSM is not in IDLE.
- `j`, output, N: registered J drive to the bank. Observable.
- `k`, output, N: registered K drive to the bank. Observable.
- `q`, output, N: bank state.

## Operation
- The FSM has three states: IDLE, DRIVE and ACK. The transitions are fixed:
  - IDLE → DRIVE when any `req` is high at the edge.
  - DRIVE → ACK unconditionally.
  - ACK → IDLE unconditionally.
- Arbitration happens only at the IDLE→DRIVE edge:
  - If one request is pending, that requester wins.
  - If both are pending, the winner is round-robin. The requester not granted last time wins.
  - The `last` pointer resets to 1, so requester 0 wins the first tie.
  - `last` updates to the winner on the IDLE→DRIVE edge.
- On the IDLE→DRIVE edge the block latches the winner's `op` and `idx`:
  - `j` and `k` are loaded one-hot at bit `idx` according to `op`.
  - All other bits of `j` and `k` are 0. All of `j` and `k` are 0 in IDLE and ACK.
- On the DRIVE→ACK edge the bank updates per JK semantics. Bits with j=k=0 hold.
- During the ACK cycle, `ack[winner]` is 1 for exactly one cycle.
- `op` = 00 (hold) performs the full handshake and leaves `q` unchanged.
- If `idx` ≥ N (possible only when N is not a power of two):
  - No bit is driven and `q` is unchanged.
  - `ack` is still pulsed.
- A losing requester keeps `req` high and is served in the next IDLE. No request is dropped.

## Timing
- All outputs are 0 while `rst` is low: `ack`=0, `busy`=0, `j`=0, `k`=0, `q`=0, FSM=IDLE, `last`=1.
- Latency: with `req` sampled high at edge E, `busy` rises after E, `q` updates at E+1, and `ack` is high in the cycle between E+1 and E+2.
- Throughput is one operation per 3 cycles at best (IDLE, DRIVE, ACK).
- Requester rules:
  - `op` and `idx` must be stable from `req` rise through `ack`.
  - `req[r]` must be low at the edge following `ack[r]`.
  - The block next samples `req` at the end of the IDLE cycle, so a `req` still high there is a new request.
- `req` changes while in DRIVE or ACK are ignored until IDLE.
- Reset asserted mid-operation:
  - The FSM, `j`, `k`, `ack` and `q` clear asynchronously.
  - The in-flight request is lost. No `ack` is issued.
  - The requester re-requests after reset release.
- First edge after `rst` rises: normal IDLE sampling.

## Configuration
- Macro `JK_ARB_FIXED_PRIO_EN`.
- When defined:
  - Requester 0 always wins simultaneous requests.
  - `last` is not implemented.
  - Requester 1 can starve under continuous requester-0 traffic.
- When undefined (default): round-robin as described in Operation.

## Test plan
- Reset, then requester 0 sends op=10, idx=3 (N=8).
  - `j`=0x08 and `k`=0 during DRIVE.
  - `q`=0x08 after the next edge.
  - `ack`=01 for one cycle, 2 edges after the `req` sample.
- From `q`=0x08, requester 1 sends toggle at idx=3, then toggle at idx=0.
  - `q`=0x00, then `q`=0x01.
  - `ack[1]` pulses for each operation.
- Both `req` high from reset: requester 0 sends set at idx 1, requester 1 sends set at idx 6.
  - Requester 0 is acked first, then requester 1 in the following 3-cycle slot.
  - Final `q`=0x42.
  - With `JK_ARB_FIXED_PRIO_EN`, requester 0 held continuously always wins.
- Hold op at idx 5 with `q`=0xFF.
  - `q` stays 0xFF.
  - `ack` still pulses.
  - `j`=`k`=0 throughout.
- `rst` driven low during DRIVE of a set at idx 2.
  - `q`, `j`, `k`, `ack` and `busy` go to 0 immediately.
  - No `ack` follows.
  - After release, the re-issued request completes normally.
- N=6, idx=7, op=11.
  - `q` is unchanged.
  - `ack` pulses.
